// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception-type encodings,
// Status bit positions and masks, and the ExcCode derivation helper.
package cp0_exc_unit_pkg;

  // CP0 register numbers reachable through MTC0/MFC0
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Exception-type encodings delivered by the upstream decoder
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [31:0] EXC_NONE = 32'hffff_ffff;

  // Status layout: EXL bit, reset value (BEV=1) and software-writable bits
  localparam int          STATUS_EXL   = 1;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  // Interrupts record ExcCode 0; every other type records its low five bits
  function automatic logic [4:0] excCodeOf(input logic [31:0] excType);
    return (excType == EXC_INT) ? 5'd0 : excType[4:0];
  endfunction

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the
// sticky timer-interrupt flag that feeds Cause.TI.
module cp0_exc_unit_timer
  import cp0_exc_unit_pkg::*;
#(
  parameter int COUNT_DIV_LOG2 = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        countWe,
  input  logic        compareWe,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timerInt
);

  // A zero divide ratio still needs a one-bit counter that wraps every cycle
  localparam int DIV_W = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((64'd1 << COUNT_DIV_LOG2) - 64'd1);

  logic [DIV_W-1:0] divReg;
  logic             divWrap;

  assign divWrap = (divReg == DIV_MAX);

  // Prescaler; a Count write restarts it so the new value holds a full period
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divReg <= '0;
    end else if (countWe || divWrap) begin
      divReg <= '0;
    end else begin
      divReg <= divReg + 1'b1;
    end
  end

  // Count: software write has priority over the prescaled increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (countWe) begin
      count <= wdata;
    end else if (divWrap) begin
      count <= count + 32'd1;
    end
  end

  // Compare register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare <= '0;
    end else if (compareWe) begin
      compare <= wdata;
    end
  end

  // Sticky TI flag; writing Compare acknowledges it, even against a same-cycle match
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timerInt <= 1'b0;
    end else if (compareWe) begin
      timerInt <= 1'b0;
    end else if ((count == compare) && (compare != 32'd0)) begin
      timerInt <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file and exception commit: updates Status/Cause/EPC/BadVAddr
// on exceptions and ERET, drives the PC redirect/flush, and serves MTC0/MFC0.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC0_0380,
  parameter int          COUNT_DIV_LOG2 = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] badaddr_i,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic        excTaken;
  logic        eretTaken;
  logic        mtc0En;
  logic        excFirst;

  logic [31:0] statusReg;
  logic [31:0] epcReg;
  logic [31:0] badVAddrReg;
  logic        causeBdReg;
  logic [4:0]  causeExcCodeReg;
  logic [1:0]  causeIpSwReg;
  logic [5:0]  causeIpHwReg;
  logic [5:0]  causeIpHwNext;
  logic [31:0] causeVal;

  logic [31:0] countVal;
  logic [31:0] compareVal;
  logic        timerInt;

  assign excTaken  = (excepttype_i != EXC_NONE) && (excepttype_i != EXC_ERET);
  assign eretTaken = (excepttype_i == EXC_ERET);
  // A commit in the same cycle swallows any MTC0 completely
  assign mtc0En    = we_i && !excTaken && !eretTaken;
  // Only a first-level exception records EPC and BD
  assign excFirst  = excTaken && !statusReg[STATUS_EXL];

  assign flush_o = excTaken || eretTaken;
  assign newpc_o = eretTaken ? epcReg : EXC_VECTOR;

  cp0_exc_unit_timer #(
    .COUNT_DIV_LOG2(COUNT_DIV_LOG2)
  ) uTimer (
    .clk      (clk),
    .resetn   (resetn),
    .countWe  (mtc0En && (waddr_i == CP0_COUNT)),
    .compareWe(mtc0En && (waddr_i == CP0_COMPARE)),
    .wdata    (wdata_i),
    .count    (countVal),
    .compare  (compareVal),
    .timerInt (timerInt)
  );

  // Status: exception sets EXL, ERET clears it, MTC0 reaches only IM/EXL/IE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      statusReg <= STATUS_RESET;
    end else if (excTaken) begin
      statusReg[STATUS_EXL] <= 1'b1;
    end else if (eretTaken) begin
      statusReg[STATUS_EXL] <= 1'b0;
    end else if (mtc0En && (waddr_i == CP0_STATUS)) begin
      statusReg <= (wdata_i & STATUS_WMASK) | STATUS_RESET;
    end
  end

  // EPC: return address of a first-level exception (branch address for delay slots)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epcReg <= '0;
    end else if (excFirst) begin
      epcReg <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
    end else if (mtc0En && (waddr_i == CP0_EPC)) begin
      epcReg <= wdata_i;
    end
  end

  // BadVAddr: captured only on address-error exceptions, never by software
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badVAddrReg <= '0;
    end else if (excTaken && ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES))) begin
      badVAddrReg <= badaddr_i;
    end
  end

  // Cause.BD and Cause.ExcCode recorded on exception commit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      causeBdReg      <= 1'b0;
      causeExcCodeReg <= '0;
    end else if (excTaken) begin
      if (!statusReg[STATUS_EXL]) begin
        causeBdReg <= in_delayslot_i;
      end
      causeExcCodeReg <= excCodeOf(excepttype_i);
    end
  end

  // Cause.IP[9:8]: software interrupt bits, the only writable part of Cause
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      causeIpSwReg <= '0;
    end else if (mtc0En && (waddr_i == CP0_CAUSE)) begin
      causeIpSwReg <= wdata_i[9:8];
    end
  end

  // Hardware line 5 is shared with the timer interrupt
  assign causeIpHwNext = {int_i[5] | timerInt, int_i[4:0]};

  for (genvar gi = 0; gi < 6; gi++) begin : gIpHw
    // Pending-interrupt bit resampled from its line every cycle
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        causeIpHwReg[gi] <= 1'b0;
      end else begin
        causeIpHwReg[gi] <= causeIpHwNext[gi];
      end
    end
  end

  assign causeVal = {causeBdReg, timerInt, 14'b0, causeIpHwReg, causeIpSwReg,
                     1'b0, causeExcCodeReg, 2'b00};

  assign status_o    = statusReg;
  assign cause_o     = causeVal;
  assign epc_o       = epcReg;
  assign timer_int_o = timerInt;

  // MFC0 read mux straight from the registers; unimplemented numbers read zero
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badVAddrReg;
      CP0_COUNT:    rdata_o = countVal;
      CP0_COMPARE:  rdata_o = compareVal;
      CP0_STATUS:   rdata_o = statusReg;
      CP0_CAUSE:    rdata_o = causeVal;
      CP0_EPC:      rdata_o = epcReg;
      default:      rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: a table of single-cycle commit/MTC0
// vectors, then directed sequences for the timer, interrupts and reset.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] badaddr_i;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cp0_exc_unit #(
    .EXC_VECTOR    (32'hBFC0_0380),
    .COUNT_DIV_LOG2(1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .raddr_i       (raddr_i),
    .rdata_o       (rdata_o),
    .int_i         (int_i),
    .excepttype_i  (excepttype_i),
    .pc_i          (pc_i),
    .in_delayslot_i(in_delayslot_i),
    .badaddr_i     (badaddr_i),
    .flush_o       (flush_o),
    .newpc_o       (newpc_o),
    .status_o      (status_o),
    .cause_o       (cause_o),
    .epc_o         (epc_o),
    .timer_int_o   (timer_int_o)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] etype;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [4:0]  raddr;
    logic        expFlush;
    logic [31:0] expNewpc;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] etype, input logic [31:0] pc, input logic ds,
                              input logic [31:0] bad, input logic [4:0] raddr,
                              input logic expFlush, input logic [31:0] expNewpc,
                              input logic [31:0] expRd);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.etype = etype; v.pc = pc; v.ds = ds;
    v.bad = bad; v.raddr = raddr; v.expFlush = expFlush; v.expNewpc = expNewpc; v.expRd = expRd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    excepttype_i = 32'hffff_ffff; pc_i = '0; in_delayslot_i = 1'b0; badaddr_i = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    step();
    we_i = 1'b0;
    $display("mtc0 reg=%0d data=%h", a, d);
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] d);
    raddr_i = a;
    #1;
    d = rdata_o;
  endtask

  localparam logic [31:0] NONE = 32'hffff_ffff;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;

  initial begin
    logic [31:0] d;
    int n;

    resetn = 1'b0; int_i = '0; raddr_i = '0;
    setIdle();

    // Directed commit / MTC0 vectors, one cycle each, applied in order
    //             we    waddr  wdata          etype          pc             ds    bad            raddr  flush newpc          rdata-after-edge
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd12, 1'b0, VEC,           32'h0040_0000));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'h4,         32'hBFC0_0102, 1'b0, 32'hBFC0_0102, 5'd14, 1'b1, VEC,           32'hBFC0_0102));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd8,  1'b0, VEC,           32'hBFC0_0102));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd13, 1'b0, VEC,           32'h0000_0010));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd12, 1'b0, VEC,           32'h0040_0002));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'he,         32'h0,         1'b0, 32'h0,         5'd12, 1'b1, 32'hBFC0_0102, 32'h0040_0000));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'h8,         32'h8000_0010, 1'b1, 32'h0,         5'd14, 1'b1, VEC,           32'h8000_000C));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd13, 1'b0, VEC,           32'h8000_0020));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'h8,         32'h8000_0100, 1'b0, 32'h1234_5678, 5'd14, 1'b1, VEC,           32'h8000_000C));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd13, 1'b0, VEC,           32'h8000_0020));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd8,  1'b0, VEC,           32'hBFC0_0102));
    vecs.push_back(mk(1'b1, 5'd14, 32'h8000_0040, NONE,          32'h0,         1'b0, 32'h0,         5'd14, 1'b0, VEC,           32'h8000_0040));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'he,         32'h0,         1'b0, 32'h0,         5'd12, 1'b1, 32'h8000_0040, 32'h0040_0000));
    vecs.push_back(mk(1'b1, 5'd12, 32'hffff_ffff, 32'hc,         32'h8000_0200, 1'b0, 32'h0,         5'd12, 1'b1, VEC,           32'h0040_0002));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd13, 1'b0, VEC,           32'h0000_0030));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'he,         32'h0,         1'b0, 32'h0,         5'd12, 1'b1, 32'h8000_0200, 32'h0040_0000));
    vecs.push_back(mk(1'b1, 5'd12, 32'hffff_ffff, NONE,          32'h0,         1'b0, 32'h0,         5'd12, 1'b0, VEC,           32'h0040_ff03));
    vecs.push_back(mk(1'b1, 5'd13, 32'hffff_ffff, NONE,          32'h0,         1'b0, 32'h0,         5'd13, 1'b0, VEC,           32'h0000_0330));
    vecs.push_back(mk(1'b1, 5'd8,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd8,  1'b0, VEC,           32'hBFC0_0102));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'h1,         32'h8000_0300, 1'b1, 32'h0,         5'd13, 1'b1, VEC,           32'h0000_0300));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         32'h5,         32'h8000_0304, 1'b0, 32'hDEAD_BEE0, 5'd8,  1'b1, VEC,           32'hDEAD_BEE0));
    vecs.push_back(mk(1'b0, 5'd0,  32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd7,  1'b0, VEC,           32'h0000_0000));
    vecs.push_back(mk(1'b1, 5'd12, 32'h0,         NONE,          32'h0,         1'b0, 32'h0,         5'd12, 1'b0, VEC,           32'h0040_0000));

    // Reset state while reset is held
    repeat (3) step();
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_newpc", newpc_o, VEC);
    readReg(5'd12, d); check("rst_status", d, 32'h0040_0000);
    readReg(5'd13, d); check("rst_cause", d, 32'h0);
    readReg(5'd14, d); check("rst_epc", d, 32'h0);
    step();
    readReg(5'd8, d);  check("rst_badvaddr", d, 32'h0);
    readReg(5'd9, d);  check("rst_count", d, 32'h0);
    readReg(5'd11, d); check("rst_compare", d, 32'h0);
    step();
    resetn = 1'b1;
    step();

    // Table-driven commit / MTC0 vectors
    for (int i = 0; i < vecs.size(); i++) begin
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; wdata_i = vecs[i].wdata;
      excepttype_i = vecs[i].etype; pc_i = vecs[i].pc; in_delayslot_i = vecs[i].ds;
      badaddr_i = vecs[i].bad; raddr_i = vecs[i].raddr;
      #1;
      check($sformatf("v%0d_flush", i), 32'(flush_o), 32'(vecs[i].expFlush));
      check($sformatf("v%0d_newpc", i), newpc_o, vecs[i].expNewpc);
      step();
      check($sformatf("v%0d_rdata", i), rdata_o, vecs[i].expRd);
      $display("vec %0d type=%h we=%0d reg=%0d -> rdata=%h", i, vecs[i].etype, vecs[i].we,
               vecs[i].raddr, rdata_o);
    end
    setIdle();
    step();

    // Timer: Compare=10, Count=0 -> TI after Count reaches 10 with a /2 prescaler
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    n = 0;
    while (timer_int_o !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("ti_latency", 32'(n), 32'd21);
    readReg(5'd9, d);  check("ti_count", d, 32'd10);
    readReg(5'd13, d); check("ti_cause30", 32'(d[30]), 32'h1);
    check("ti_ip7_lag", 32'(d[15]), 32'h0);
    step();
    readReg(5'd13, d); check("ti_ip7", 32'(d[15]), 32'h1);
    repeat (4) step();
    check("ti_sticky", 32'(timer_int_o), 32'h1);
    $display("timer match after %0d cycles", n);

    // Compare write acknowledges TI; IP7 follows a cycle later
    mtc0(5'd11, 32'd10);
    check("ti_clear", 32'(timer_int_o), 32'h0);
    step();
    readReg(5'd13, d); check("ti_ip7_clear", 32'(d[15]), 32'h0);

    // Clear on Compare write beats a same-cycle match
    mtc0(5'd11, 32'd50);
    mtc0(5'd9, 32'd50);
    mtc0(5'd11, 32'd50);
    check("clr_wins", 32'(timer_int_o), 32'h0);
    step();
    check("match_after_clr", 32'(timer_int_o), 32'h1);
    mtc0(5'd11, 32'd0);
    check("ti_off", 32'(timer_int_o), 32'h0);

    // Count write wins over the increment and restarts the prescaler
    mtc0(5'd9, 32'd100);
    readReg(5'd9, d); check("cnt_write", d, 32'd100);
    step();
    readReg(5'd9, d); check("cnt_hold", d, 32'd100);
    step();
    readReg(5'd9, d); check("cnt_inc", d, 32'd101);

    // Count wraps to zero
    mtc0(5'd9, 32'hffff_ffff);
    step();
    step();
    readReg(5'd9, d); check("cnt_wrap", d, 32'd0);

    // Hardware interrupt lines latched into Cause[15:10]
    int_i = 6'b100101;
    step();
    readReg(5'd13, d); check("int_ip", 32'(d[15:10]), 32'h25);
    $display("int_i=%b cause=%h", int_i, d);
    int_i = 6'b000000;
    step();
    readReg(5'd13, d); check("int_ip_clr", 32'(d[15:10]), 32'h0);

    // Reset asserted mid-cycle clears state without waiting for an edge
    mtc0(5'd14, 32'h1234_5678);
    mtc0(5'd12, 32'h0000_0003);
    #2;
    resetn = 1'b0;
    #1;
    check("mrst_status", status_o, 32'h0040_0000);
    check("mrst_epc", epc_o, 32'h0);
    check("mrst_cause", cause_o, 32'h0);
    readReg(5'd8, d); check("mrst_badvaddr", d, 32'h0);
    $display("mid-run reset: status=%h epc=%h", status_o, epc_o);
    step();
    resetn = 1'b1;
    step();
    check("post_rst_flush", 32'(flush_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
